dbg_apb_interconnect: RTL and testbench

- Parametrised APB4 interconnect for the JTAG debug path.
- Accepts single transactions from a debug-side requester through a valid/ready request and a one-cycle response pulse.
- Decodes the address onto one of NR_SLAVES equal-size windows and runs the IDLE/SETUP/ACCESS protocol on a shared APB bus, including wait states.
- Reports decode errors and slave errors; an optional ACCESS timeout converts a hung slave into an error response.

---
 rtl/dbg_apb_interconnect.sv | 161 ++++++++++++++++
 tb/tb_dbg_apb_interconnect.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dbg_apb_interconnect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dbg_apb_interconnect                                            |
// | Desc     : APB4 interconnect for the JTAG debug path. Optional ACCESS       |
// |            timeout enabled by defining DBG_APB_TIMEOUT_EN.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dbg_apb_interconnect #(
   parameter int                      ADDR_WIDTH      = 32,
   parameter int                      DATA_WIDTH      = 32,
   parameter int                      NR_SLAVES       = 4,
   parameter int                      SLAVE_ADDR_BITS = 12,
   parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR       = '0,
   parameter int                      TIMEOUT_CYCLES  = 255,
   localparam int                     STRB_W          = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [STRB_W-1:0]     req_strb,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [NR_SLAVES-1:0]  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   output logic [STRB_W-1:0]     pstrb,
   input  logic [DATA_WIDTH-1:0] prdata [NR_SLAVES],
   input  logic [NR_SLAVES-1:0]  pready,
   input  logic [NR_SLAVES-1:0]  pslverr
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_DECERR = 2'd3;

   if ((DATA_WIDTH % 8) != 0 || NR_SLAVES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("dbg_apb_interconnect: illegal parameter combination");
   end

   logic [1:0]            r_state;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic                  w_hit;
   logic [NR_SLAVES-1:0]  w_sel_dec;
   logic                  w_pready;
   logic                  w_pslverr;
   logic [DATA_WIDTH-1:0] w_prdata;

   assign req_ready = (r_state == S_IDLE);

   // Window index; the subtraction wraps for addresses below BASE_ADDR, hence the explicit >= test.
   assign w_idx = (req_addr - BASE_ADDR) >> SLAVE_ADDR_BITS;
   assign w_hit = (req_addr >= BASE_ADDR) && (w_idx < ADDR_WIDTH'(NR_SLAVES));

   always_comb begin
      w_sel_dec = '0;
      w_pready  = 1'b0;
      w_pslverr = 1'b0;
      w_prdata  = '0;
      for (int i = 0; i < NR_SLAVES; i++) begin
         w_sel_dec[i] = w_hit && (w_idx == ADDR_WIDTH'(i));
         w_pready     = w_pready  | (psel[i] & pready[i]);
         w_pslverr    = w_pslverr | (psel[i] & pslverr[i]);
         w_prdata     = w_prdata  | ({DATA_WIDTH{psel[i]}} & prdata[i]);
      end
   end

`ifdef DBG_APB_TIMEOUT_EN
   localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0]  c_limit = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_timeout;

   // Fires on the ACCESS cycle whose increment would bring the count to TIMEOUT_CYCLES.
   assign w_timeout = (r_cnt == c_limit) && !w_pready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_state == S_SETUP) begin
         r_cnt <= '0;
      end else if (r_state == S_ACCESS && !w_pready) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
`else
   logic w_timeout;
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         psel      <= '0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         pstrb     <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  paddr  <= req_addr;
                  pwrite <= req_write;
                  pwdata <= req_wdata;
                  pstrb  <= req_write ? req_strb : '0;
                  if (w_hit) begin
                     psel    <= w_sel_dec;
                     r_state <= S_SETUP;
                  end else begin
                     r_state <= S_DECERR;
                  end
               end
            end
            S_SETUP: begin
               penable <= 1'b1;
               r_state <= S_ACCESS;
            end
            S_ACCESS: begin
               if (w_pready) begin
                  psel      <= '0;
                  penable   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= w_pslverr;
                  rsp_rdata <= (!pwrite && !w_pslverr) ? w_prdata : '0;
                  r_state   <= S_IDLE;
               end else if (w_timeout) begin
                  psel      <= '0;
                  penable   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  r_state   <= S_IDLE;
               end
            end
            S_DECERR: begin
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b1;
               rsp_rdata <= '0;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dbg_apb_interconnect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dbg_apb_interconnect                                         |
// | Desc     : Directed self-checking bench for dbg_apb_interconnect.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dbg_apb_interconnect;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_strb;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [3:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata [4];
   logic [3:0]  pready;
   logic [3:0]  pslverr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dbg_apb_interconnect #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NR_SLAVES(4), .SLAVE_ADDR_BITS(12),
      .BASE_ADDR(32'h0), .TIMEOUT_CYCLES(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
      .pslverr(pslverr)
   );

   // Advance to 1 time unit after the next rising edge; all drive and sample happens there.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic v, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
      req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_strb = s;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      pready = 4'h0; pslverr = 4'h0;
      for (int i = 0; i < 4; i++) prdata[i] = 32'h0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
      checks++; if (psel !== 4'h0 || penable !== 1'b0) begin errors++; $display("FAIL reset_bus got psel=%b pen=%b exp 0000/0", psel, penable); end
      checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp got v=%b e=%b d=%h exp 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
      checks++; if (paddr !== 32'h0 || pwdata !== 32'h0 || pstrb !== 4'h0 || pwrite !== 1'b0) begin errors++; $display("FAIL reset_regs got a=%h d=%h s=%b w=%b exp zeros", paddr, pwdata, pstrb, pwrite); end
   endtask

   task automatic test_read_zero_wait();
      // Other slaves report ready with error: must be ignored.
      pready = 4'b1111; pslverr = 4'b1101;
      prdata[0] = 32'h11111111; prdata[1] = 32'hCAFEF00D;
      prdata[2] = 32'h22222222; prdata[3] = 32'h33333333;
      set_req(1'b1, 1'b0, 32'h0000_1004, 32'hFFFF_FFFF, 4'hF);
      tick();
      set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      checks++; if (psel !== 4'b0010 || penable !== 1'b0) begin errors++; $display("FAIL rd_setup got psel=%b pen=%b exp 0010/0", psel, penable); end
      checks++; if (paddr !== 32'h1004 || pwrite !== 1'b0 || pstrb !== 4'h0) begin errors++; $display("FAIL rd_addr got a=%h w=%b s=%b exp 1004/0/0000", paddr, pwrite, pstrb); end
      tick();
      checks++; if (psel !== 4'b0010 || penable !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_access got psel=%b pen=%b v=%b exp 0010/1/0", psel, penable, rsp_valid); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D || rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp got v=%b d=%h e=%b exp 1/cafef00d/0", rsp_valid, rsp_rdata, rsp_err); end
      checks++; if (psel !== 4'h0 || penable !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rd_done got psel=%b pen=%b rdy=%b exp 0000/0/1", psel, penable, req_ready); end
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_pulse got %b exp 0", rsp_valid); end
   endtask

   task automatic test_write_wait();
      pready = 4'b0000; pslverr = 4'b0100;
      set_req(1'b1, 1'b1, 32'h0000_2010, 32'h1234_5678, 4'b0110);
      tick();
      set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      checks++; if (psel !== 4'b0100 || pwrite !== 1'b1) begin errors++; $display("FAIL wr_setup got psel=%b w=%b exp 0100/1", psel, pwrite); end
      tick();
      for (int i = 0; i < 3; i++) begin
         checks++; if (penable !== 1'b1 || rsp_valid !== 1'b0 || pwdata !== 32'h1234_5678 || pstrb !== 4'b0110) begin errors++; $display("FAIL wr_wait%0d got pen=%b v=%b d=%h s=%b exp 1/0/12345678/0110", i, penable, rsp_valid, pwdata, pstrb); end
         tick();
      end
      pready = 4'b0100; pslverr = 4'b0000;
      checks++; if (penable !== 1'b1 || paddr !== 32'h2010) begin errors++; $display("FAIL wr_last got pen=%b a=%h exp 1/2010", penable, paddr); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rsp got v=%b e=%b d=%h exp 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
      checks++; if (pwdata !== 32'h1234_5678 || pstrb !== 4'b0110) begin errors++; $display("FAIL wr_hold got d=%h s=%b exp 12345678/0110", pwdata, pstrb); end
      pready = 4'b0000;
      tick();
   endtask

   task automatic test_decode_miss();
      set_req(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'hF);
      tick();
      set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      checks++; if (psel !== 4'h0 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL dec_mid got psel=%b rdy=%b v=%b exp 0000/0/0", psel, req_ready, rsp_valid); end
      checks++; if (pstrb !== 4'h0 || paddr !== 32'h4000) begin errors++; $display("FAIL dec_latch got s=%b a=%h exp 0000/4000", pstrb, paddr); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || psel !== 4'h0) begin errors++; $display("FAIL dec_rsp got v=%b e=%b d=%h psel=%b exp 1/1/0/0000", rsp_valid, rsp_err, rsp_rdata, psel); end
      tick();
   endtask

   task automatic test_back_to_back();
      pready = 4'b1001; pslverr = 4'b1000;
      prdata[0] = 32'h1111_2222; prdata[3] = 32'hDEAD_BEEF;
      set_req(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'h0);
      tick();
      set_req(1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0);
      checks++; if (psel !== 4'b1000 || req_ready !== 1'b0) begin errors++; $display("FAIL b2b_setup got psel=%b rdy=%b exp 1000/0", psel, req_ready); end
      tick();
      checks++; if (req_ready !== 1'b0 || penable !== 1'b1) begin errors++; $display("FAIL b2b_access got rdy=%b pen=%b exp 0/1", req_ready, penable); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin errors++; $display("FAIL b2b_err got v=%b e=%b d=%h rdy=%b exp 1/1/0/1", rsp_valid, rsp_err, rsp_rdata, req_ready); end
      tick();
      set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      checks++; if (psel !== 4'b0001 || paddr !== 32'h0008 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_second got psel=%b a=%h v=%b exp 0001/8/0", psel, paddr, rsp_valid); end
      tick(); tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h1111_2222) begin errors++; $display("FAIL b2b_rsp got v=%b e=%b d=%h exp 1/0/11112222", rsp_valid, rsp_err, rsp_rdata); end
      pready = 4'b0000; pslverr = 4'b0000;
      tick();
   endtask

   task automatic test_timeout();
      int seen;
      pready = 4'b0000;
      set_req(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'h0);
      tick();
      set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
`ifdef DBG_APB_TIMEOUT_EN
      tick(); tick(); tick();
      checks++; if (penable !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL to_last got pen=%b v=%b exp 1/0", penable, rsp_valid); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || psel !== 4'h0 || penable !== 1'b0) begin errors++; $display("FAIL to_abort got v=%b e=%b d=%h psel=%b pen=%b exp 1/1/0/0000/0", rsp_valid, rsp_err, rsp_rdata, psel, penable); end
      tick();
`else
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         if (rsp_valid === 1'b1) seen++;
         tick();
      end
      checks++; if (seen !== 0 || penable !== 1'b1 || psel !== 4'b0001) begin errors++; $display("FAIL to_hang got rsp_count=%0d pen=%b psel=%b exp 0/1/0001", seen, penable, psel); end
      pready = 4'b0001;
      tick();
      pready = 4'b0000;
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL to_release got v=%b e=%b exp 1/0", rsp_valid, rsp_err); end
      tick();
`endif
   endtask

   task automatic test_reset_mid_access();
      int seen;
      pready = 4'b0000;
      set_req(1'b1, 1'b1, 32'h0000_1000, 32'hAAAA_5555, 4'hF);
      tick();
      set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      checks++; if (penable !== 1'b1 || psel !== 4'b0010) begin errors++; $display("FAIL rst_pre got pen=%b psel=%b exp 1/0010", penable, psel); end
      rst_n = 1'b0;
      tick();
      checks++; if (psel !== 4'h0 || penable !== 1'b0 || paddr !== 32'h0 || pwdata !== 32'h0 || pstrb !== 4'h0 || pwrite !== 1'b0) begin errors++; $display("FAIL rst_mid got psel=%b pen=%b a=%h d=%h s=%b w=%b exp zeros", psel, penable, paddr, pwdata, pstrb, pwrite); end
      checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp got v=%b e=%b d=%h exp 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
      rst_n = 1'b1;
      pready = 4'b1111;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rsp_valid === 1'b1) seen++;
      end
      checks++; if (seen !== 0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_after got rsp_count=%0d rdy=%b exp 0/1", seen, req_ready); end
   endtask

   initial begin
      test_reset();
      test_read_zero_wait();
      test_write_wait();
      test_decode_miss();
      test_back_to_back();
      test_timeout();
      test_reset_mid_access();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
